// File: rtl/fir_inv_pkg.sv
// Shared widths, FSM state encoding and saturation limits for the inverse FIR.
package fir_inv_pkg;
  localparam int ACC_W = 24;
  localparam int X_W   = 8;
  localparam int Y_W   = 16;
  localparam int P_W   = 2 * X_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 24'sd127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -24'sd128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/fir_inv_mac.sv
// Combinational multiply-subtract: o_res = i_acc - i_h * i_x (16-bit product).
module fir_inv_mac
  import fir_inv_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [X_W-1:0]   i_h,
  input  logic signed [X_W-1:0]   i_x,
  output logic signed [ACC_W-1:0] o_res
);
  logic signed [P_W-1:0] w_prod;

  assign w_prod = i_h * i_x;
  assign o_res  = i_acc - {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};
endmodule

// File: rtl/fir_4tap_inv.sv
// Recovers x[n] from a 4-tap filtered stream using its own past outputs,
// one tap per cycle through a shared multiply-subtract.
module fir_4tap_inv
  import fir_inv_pkg::*;
#(
  parameter int                      H0_SHIFT = 0,
  parameter logic signed [X_W-1:0]   H1       = 8'sd2,
  parameter logic signed [X_W-1:0]   H2       = 8'sd2,
  parameter logic signed [X_W-1:0]   H3       = 8'sd1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic signed [Y_W-1:0] Yin,
  input  logic                  Yin_valid,
  output logic                  Yin_ready,
  output logic signed [X_W-1:0] Xout,
  output logic                  Xout_valid,
  input  logic                  Xout_ready,
  output logic                  Sat
);
  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [1:0]              r_k;
  logic signed [X_W-1:0]   r_hist [3];

  logic signed [X_W-1:0]   w_h;
  logic signed [X_W-1:0]   w_x;
  logic signed [ACC_W-1:0] w_mac;
  logic signed [ACC_W-1:0] w_shift;
  logic                    w_hi;
  logic                    w_lo;
  logic signed [X_W-1:0]   w_xsat;

  assign Yin_ready = (r_state == IDLE);

  // Tap k pairs Hk with x[n-k], which sits in hist[k-1].
  always_comb begin
    w_h = H3;
    w_x = r_hist[2];
    case (r_k)
      2'd1: begin w_h = H1; w_x = r_hist[0]; end
      2'd2: begin w_h = H2; w_x = r_hist[1]; end
      default: ;
    endcase
  end

  fir_inv_mac u_mac (
    .i_acc (r_acc),
    .i_h   (w_h),
    .i_x   (w_x),
    .o_res (w_mac)
  );

  assign w_shift = r_acc >>> H0_SHIFT;
  assign w_hi    = (w_shift > SAT_MAX);
  assign w_lo    = (w_shift < SAT_MIN);
  assign w_xsat  = w_hi ? 8'sd127 : (w_lo ? -8'sd128 : w_shift[X_W-1:0]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_k        <= '0;
      Xout       <= '0;
      Xout_valid <= 1'b0;
      Sat        <= 1'b0;
      for (int i = 0; i < 3; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        IDLE: if (Yin_valid) begin
          r_acc   <= {{(ACC_W-Y_W){Yin[Y_W-1]}}, Yin};
          r_k     <= 2'd1;
          r_state <= MAC;
        end
        MAC: begin
          r_acc <= w_mac;
          if (r_k == 2'd3) begin
            r_k     <= 2'd0;
            r_state <= SCALE;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        SCALE: begin
          Xout       <= w_xsat;
          Sat        <= w_hi | w_lo;
          Xout_valid <= 1'b1;
          r_hist[0]  <= w_xsat;
          r_hist[1]  <= r_hist[0];
          r_hist[2]  <= r_hist[1];
          r_state    <= OUT;
        end
        OUT: if (Xout_ready) begin
          Xout_valid <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_4tap_inv.sv
// Directed bench for fir_4tap_inv; a second instance runs with H0_SHIFT = 1.
module tb_fir_4tap_inv;
  logic               Clk = 1'b0;
  logic               Reset = 1'b1;
  logic signed [15:0] Yin = '0;
  logic               Yin_valid = 1'b0;
  logic               Xout_ready = 1'b1;
  logic               Yin_ready, Xout_valid, Sat;
  logic signed [7:0]  Xout;
  logic               Yin_ready_s1, Xout_valid_s1, Sat_s1;
  logic signed [7:0]  Xout_s1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  fir_4tap_inv u_dut (
    .Clk(Clk), .Reset(Reset), .Yin(Yin), .Yin_valid(Yin_valid),
    .Yin_ready(Yin_ready), .Xout(Xout), .Xout_valid(Xout_valid),
    .Xout_ready(Xout_ready), .Sat(Sat)
  );

  fir_4tap_inv #(.H0_SHIFT(1)) u_dut_s1 (
    .Clk(Clk), .Reset(Reset), .Yin(Yin), .Yin_valid(Yin_valid),
    .Yin_ready(Yin_ready_s1), .Xout(Xout_s1), .Xout_valid(Xout_valid_s1),
    .Xout_ready(Xout_ready), .Sat(Sat_s1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Yin_valid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  // Present one sample and wait for the result; does not consume it.
  task automatic send(input int y);
    int n;
    n = 0;
    while (!Yin_ready && n < 10) begin tick(); n++; end
    if (!Yin_ready) chk("tmo_ready", 0, 1);
    Yin = 16'(y);
    Yin_valid = 1'b1;
    tick();
    Yin_valid = 1'b0;
    n = 0;
    while (!Xout_valid && n < 10) begin tick(); n++; end
    if (!Xout_valid) chk("tmo_valid", 0, 1);
  endtask

  task automatic take();
    Xout_ready = 1'b1;
    tick();
  endtask

  task automatic run(input string tag, input int y, input int ex, input int es);
    send(y);
    chk({tag, "_x"}, int'(Xout), ex);
    chk({tag, "_sat"}, int'(Sat), es);
    take();
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_xout", int'(Xout), 0);
    chk("rst_valid", int'(Xout_valid), 0);
    chk("rst_sat", int'(Sat), 0);
    chk("rst_ready", int'(Yin_ready), 1);

    // basic inversion; shifted instance checked on first sample
    send(-3);
    chk("seq0_x", int'(Xout), -3);
    chk("seq0_sat", int'(Sat), 0);
    chk("sh1_x", int'(Xout_s1), -2);
    chk("sh1_sat", int'(Sat_s1), 0);
    take();
    run("seq1", -5, 1, 0);
    run("seq2", -4, 0, 0);
    run("seq3", -3, -2, 0);

    // cycle-accurate latency
    do_reset();
    Xout_ready = 1'b1;
    Yin = 16'sd7;
    Yin_valid = 1'b1;
    tick();
    Yin_valid = 1'b0;
    chk("lat_e0_valid", int'(Xout_valid), 0);
    chk("lat_e0_ready", int'(Yin_ready), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("lat_mac_valid", int'(Xout_valid), 0);
      chk("lat_mac_ready", int'(Yin_ready), 0);
    end
    tick();
    chk("lat_e4_valid", int'(Xout_valid), 1);
    chk("lat_e4_x", int'(Xout), 7);
    chk("lat_e4_ready", int'(Yin_ready), 0);
    tick();
    chk("lat_e5_valid", int'(Xout_valid), 0);
    chk("lat_e5_ready", int'(Yin_ready), 1);

    // saturation both ways
    do_reset();
    run("sat_hi", 1000, 127, 1);
    run("sat_lo", 0, -128, 1);

    // output stall: held result, inputs ignored
    do_reset();
    Xout_ready = 1'b0;
    send(10);
    Yin_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Yin = 16'(20 + 7 * i);
      tick();
      chk("stall_x", int'(Xout), 10);
      chk("stall_sat", int'(Sat), 0);
      chk("stall_valid", int'(Xout_valid), 1);
      chk("stall_ready", int'(Yin_ready), 0);
    end
    Yin_valid = 1'b0;
    take();
    chk("stall_rel_valid", int'(Xout_valid), 0);
    chk("stall_rel_ready", int'(Yin_ready), 1);
    run("stall_next", 20, 0, 0);

    // reset mid-MAC clears in-flight sample and history
    do_reset();
    run("mid_first", 3, 3, 0);
    Yin = 16'sd9;
    Yin_valid = 1'b1;
    tick();
    Yin_valid = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_valid", int'(Xout_valid), 0);
    chk("mid_ready", int'(Yin_ready), 1);
    run("mid_after", 5, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
